// File: rtl/if_pc_pkg.sv
// Shared types and constants for the fetch-stage PC generator.
package if_pc_pkg;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HANDLE = 1'b1
  } state_e;

  localparam logic [1:0]  CAUSE_NONE = 2'b00;
  localparam logic [1:0]  CAUSE_EXC  = 2'b01;
  localparam logic [1:0]  CAUSE_IRQ  = 2'b10;

  // Word addresses; the handler entry sits inside the 7-bit ROM space.
  localparam logic [31:0] DEF_RESET_PC   = 32'h0000_0000;
  localparam logic [31:0] DEF_HANDLER_PC = 32'h0000_0040;

  function automatic logic [31:0] pc_inc(input logic [31:0] pc);
    return pc + 32'd1;
  endfunction

endpackage

// File: rtl/irq_sync2.sv
// Two-flop synchroniser for the level interrupt line; resets to 0 asynchronously.
module irq_sync2 (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/if_pc_gen.sv
// Fetch PC generator: next-PC select, RUN/HANDLE tracking, EPC/cause; redirect decided and flushed in the same cycle.
// Interrupt path (synchroniser, irq_ack) exists only when IF_PC_IRQ_EN is defined.
module if_pc_gen
  import if_pc_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEF_RESET_PC,
  parameter logic [31:0] HANDLER_PC = DEF_HANDLER_PC
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_stall,
  input  logic        i_br_taken,
  input  logic [31:0] i_br_target,
  input  logic        i_exc_req,
  input  logic [31:0] i_exc_pc,
  input  logic        i_irq,
  input  logic        i_eret,
  output logic [31:0] o_pc,
  output logic        o_gohandle_or_not,
  output logic [31:0] o_epc,
  output logic [1:0]  o_cause,
  output logic        o_in_handler,
  output logic        o_irq_ack,
  output logic        o_double_fault
);

  state_e      r_state;
  state_e      w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] w_pc_nxt;
  logic [31:0] r_epc;
  logic [31:0] w_epc_nxt;
  logic [1:0]  r_cause;
  logic [1:0]  w_cause_nxt;
  logic        r_double_fault;
  logic        w_double_fault_nxt;

  logic        w_irq_s;
  logic        w_in_run;
  logic        w_in_handle;
  logic        w_take_exc;
  logic        w_take_irq;
  logic        w_take_eret;
  logic [31:0] w_seq_pc;

`ifdef IF_PC_IRQ_EN
  irq_sync2 u_irq_sync2 (
    .i_clk   (i_clk),
    .i_rst_n (i_rst),
    .i_d     (i_irq),
    .o_q     (w_irq_s)
  );
`else
  logic w_irq_unused;
  assign w_irq_unused = i_irq;
  assign w_irq_s      = 1'b0;
`endif

  assign w_in_run    = (r_state == ST_RUN);
  assign w_in_handle = (r_state == ST_HANDLE);

  // Exception beats interrupt; irq_s is masked while in HANDLE.
  assign w_take_exc  = w_in_run & i_exc_req;
  assign w_take_irq  = w_in_run & w_irq_s & ~i_exc_req;
  assign w_take_eret = w_in_handle & i_eret;

  // Return point for an interrupt: where fetch would have gone this cycle.
  assign w_seq_pc = i_br_taken ? i_br_target :
                    (i_stall   ? r_pc        : pc_inc(r_pc));

  always_comb begin
    w_state_nxt        = r_state;
    w_pc_nxt           = r_pc;
    w_epc_nxt          = r_epc;
    w_cause_nxt        = r_cause;
    w_double_fault_nxt = r_double_fault | (w_in_handle & i_exc_req);

    if (w_take_exc) begin
      w_pc_nxt    = HANDLER_PC;
      w_epc_nxt   = pc_inc(i_exc_pc);
      w_cause_nxt = CAUSE_EXC;
      w_state_nxt = ST_HANDLE;
    end else if (w_take_irq) begin
      w_pc_nxt    = HANDLER_PC;
      w_epc_nxt   = w_seq_pc;
      w_cause_nxt = CAUSE_IRQ;
      w_state_nxt = ST_HANDLE;
    end else if (w_take_eret) begin
      w_pc_nxt    = r_epc;
      w_state_nxt = ST_RUN;
    end else if (i_br_taken && !i_stall) begin
      w_pc_nxt = i_br_target;
    end else if (!i_stall) begin
      w_pc_nxt = pc_inc(r_pc);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state        <= ST_RUN;
      r_pc           <= RESET_PC;
      r_epc          <= 32'd0;
      r_cause        <= CAUSE_NONE;
      r_double_fault <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_pc           <= w_pc_nxt;
      r_epc          <= w_epc_nxt;
      r_cause        <= w_cause_nxt;
      r_double_fault <= w_double_fault_nxt;
    end
  end

  // Combinational outputs are gated so they read 0 throughout reset.
  assign o_gohandle_or_not = i_rst & (w_take_exc | w_take_irq | w_take_eret);
  assign o_irq_ack         = i_rst & w_take_irq;
  assign o_in_handler      = i_rst & w_in_handle;

  assign o_pc           = r_pc;
  assign o_epc          = r_epc;
  assign o_cause        = r_cause;
  assign o_double_fault = r_double_fault;

endmodule

// File: tb/tb_if_pc_gen.sv
// Directed self-checking bench for if_pc_gen; interrupt scenarios follow IF_PC_IRQ_EN.
module tb_if_pc_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        br_taken;
  logic [31:0] br_target;
  logic        exc_req;
  logic [31:0] exc_pc;
  logic        irq;
  logic        eret;
  logic [31:0] pc;
  logic        go;
  logic [31:0] epc;
  logic [1:0]  cause;
  logic        in_handler;
  logic        irq_ack;
  logic        double_fault;

  int errors = 0;
  int checks = 0;

  if_pc_gen dut (
    .i_clk             (clk),
    .i_rst             (rst),
    .i_stall           (stall),
    .i_br_taken        (br_taken),
    .i_br_target       (br_target),
    .i_exc_req         (exc_req),
    .i_exc_pc          (exc_pc),
    .i_irq             (irq),
    .i_eret            (eret),
    .o_pc              (pc),
    .o_gohandle_or_not (go),
    .o_epc             (epc),
    .o_cause           (cause),
    .o_in_handler      (in_handler),
    .o_irq_ack         (irq_ack),
    .o_double_fault    (double_fault)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; stall = 1'b0; br_taken = 1'b0; br_target = 32'd0;
    exc_req = 1'b1; exc_pc = 32'd0; irq = 1'b0; eret = 1'b0;
    #2;
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL rst_pc got=%h exp=%h", pc, 32'h0); end
    checks++; if (go !== 1'b0) begin errors++; $display("FAIL rst_go got=%b exp=0", go); end
    checks++; if (in_handler !== 1'b0) begin errors++; $display("FAIL rst_in_handler got=%b exp=0", in_handler); end
    checks++; if (epc !== 32'h0 || cause !== 2'b00) begin errors++; $display("FAIL rst_epc_cause got=%h/%b exp=0/00", epc, cause); end
    checks++; if (double_fault !== 1'b0 || irq_ack !== 1'b0) begin errors++; $display("FAIL rst_df_ack got=%b/%b exp=0/0", double_fault, irq_ack); end
    tick();
    tick();
    exc_req = 1'b0;
    rst = 1'b1;
    #1;
  endtask

  task automatic test_sequential();
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL seq_start got=%h exp=%h", pc, 32'h0); end
    for (int i = 1; i <= 4; i++) begin
      tick();
      checks++; if (pc !== 32'(i) || go !== 1'b0) begin errors++; $display("FAIL seq_pc got=%h/%b exp=%h/0", pc, go, 32'(i)); end
    end
  endtask

  task automatic test_branch();
    tick();
    checks++; if (pc !== 32'h5) begin errors++; $display("FAIL br_pre got=%h exp=%h", pc, 32'h5); end
    stall = 1'b1; br_taken = 1'b1; br_target = 32'h20;
    tick();
    checks++; if (pc !== 32'h5) begin errors++; $display("FAIL br_stall got=%h exp=%h", pc, 32'h5); end
    stall = 1'b0;
    tick();
    checks++; if (pc !== 32'h20) begin errors++; $display("FAIL br_taken got=%h exp=%h", pc, 32'h20); end
    br_target = 32'h9;
    tick();
    br_taken = 1'b0;
    checks++; if (pc !== 32'h9) begin errors++; $display("FAIL br_to9 got=%h exp=%h", pc, 32'h9); end
  endtask

  task automatic test_exception();
    exc_req = 1'b1; exc_pc = 32'h7; stall = 1'b1;
    #1;
    checks++; if (go !== 1'b1 || irq_ack !== 1'b0) begin errors++; $display("FAIL exc_go got=%b/%b exp=1/0", go, irq_ack); end
    tick();
    exc_req = 1'b0; stall = 1'b0;
    #1;
    checks++; if (pc !== 32'h40) begin errors++; $display("FAIL exc_pc got=%h exp=%h", pc, 32'h40); end
    checks++; if (epc !== 32'h8 || cause !== 2'b01) begin errors++; $display("FAIL exc_epc_cause got=%h/%b exp=8/01", epc, cause); end
    checks++; if (in_handler !== 1'b1 || go !== 1'b0) begin errors++; $display("FAIL exc_state got=%b/%b exp=1/0", in_handler, go); end
    tick();
    checks++; if (pc !== 32'h41) begin errors++; $display("FAIL handler_seq got=%h exp=%h", pc, 32'h41); end
    stall = 1'b1;
    tick();
    stall = 1'b0;
    checks++; if (pc !== 32'h41) begin errors++; $display("FAIL handler_stall got=%h exp=%h", pc, 32'h41); end
  endtask

  task automatic test_eret();
    eret = 1'b1;
    #1;
    checks++; if (go !== 1'b1) begin errors++; $display("FAIL eret_go got=%b exp=1", go); end
    tick();
    eret = 1'b0;
    checks++; if (pc !== 32'h8 || in_handler !== 1'b0) begin errors++; $display("FAIL eret_ret got=%h/%b exp=8/0", pc, in_handler); end
    checks++; if (cause !== 2'b01 || double_fault !== 1'b0) begin errors++; $display("FAIL eret_cause got=%b/%b exp=01/0", cause, double_fault); end
    eret = 1'b1;
    #1;
    checks++; if (go !== 1'b0) begin errors++; $display("FAIL eret_in_run_go got=%b exp=0", go); end
    tick();
    eret = 1'b0;
    checks++; if (pc !== 32'h9 || in_handler !== 1'b0) begin errors++; $display("FAIL eret_in_run got=%h/%b exp=9/0", pc, in_handler); end
  endtask

  task automatic test_double_fault();
    exc_req = 1'b1; exc_pc = 32'h30;
    tick();
    exc_req = 1'b0;
    checks++; if (pc !== 32'h40 || epc !== 32'h31) begin errors++; $display("FAIL df_enter got=%h/%h exp=40/31", pc, epc); end
    exc_req = 1'b1; eret = 1'b1;
    #1;
    checks++; if (go !== 1'b1) begin errors++; $display("FAIL df_go got=%b exp=1", go); end
    tick();
    exc_req = 1'b0; eret = 1'b0;
    checks++; if (pc !== 32'h31 || in_handler !== 1'b0) begin errors++; $display("FAIL df_ret got=%h/%b exp=31/0", pc, in_handler); end
    checks++; if (double_fault !== 1'b1) begin errors++; $display("FAIL df_set got=%b exp=1", double_fault); end
    tick();
    tick();
    checks++; if (double_fault !== 1'b1 || pc !== 32'h33) begin errors++; $display("FAIL df_hold got=%b/%h exp=1/33", double_fault, pc); end
  endtask

`ifdef IF_PC_IRQ_EN
  task automatic test_irq();
    br_taken = 1'b1; br_target = 32'h10;
    tick();
    br_taken = 1'b0;
    checks++; if (pc !== 32'h10) begin errors++; $display("FAIL irq_pre got=%h exp=%h", pc, 32'h10); end
    irq = 1'b1;
    tick();
    checks++; if (irq_ack !== 1'b0 || pc !== 32'h11) begin errors++; $display("FAIL irq_sync1 got=%b/%h exp=0/11", irq_ack, pc); end
    tick();
    checks++; if (irq_ack !== 1'b1 || go !== 1'b1 || pc !== 32'h12) begin errors++; $display("FAIL irq_ack got=%b/%b/%h exp=1/1/12", irq_ack, go, pc); end
    tick();
    checks++; if (pc !== 32'h40 || epc !== 32'h13 || cause !== 2'b10) begin errors++; $display("FAIL irq_enter got=%h/%h/%b exp=40/13/10", pc, epc, cause); end
    checks++; if (irq_ack !== 1'b0 || in_handler !== 1'b1) begin errors++; $display("FAIL irq_single got=%b/%b exp=0/1", irq_ack, in_handler); end
    tick();
    checks++; if (irq_ack !== 1'b0 || pc !== 32'h41) begin errors++; $display("FAIL irq_masked got=%b/%h exp=0/41", irq_ack, pc); end
    eret = 1'b1;
    tick();
    eret = 1'b0;
    checks++; if (pc !== 32'h13 || in_handler !== 1'b0 || irq_ack !== 1'b1) begin errors++; $display("FAIL irq_reentry got=%h/%b/%b exp=13/0/1", pc, in_handler, irq_ack); end
    irq = 1'b0;
    tick();
    checks++; if (pc !== 32'h40 || epc !== 32'h14) begin errors++; $display("FAIL irq_reenter got=%h/%h exp=40/14", pc, epc); end
    tick();
    tick();
    eret = 1'b1;
    tick();
    eret = 1'b0;
    checks++; if (pc !== 32'h14 || irq_ack !== 1'b0 || in_handler !== 1'b0) begin errors++; $display("FAIL irq_quiet got=%h/%b/%b exp=14/0/0", pc, irq_ack, in_handler); end
  endtask

  task automatic test_exc_irq_same();
    irq = 1'b1;
    tick();
    tick();
    exc_req = 1'b1; exc_pc = 32'hFFFF_FFFF;
    #1;
    checks++; if (irq_ack !== 1'b0 || go !== 1'b1) begin errors++; $display("FAIL same_prio got=%b/%b exp=0/1", irq_ack, go); end
    tick();
    exc_req = 1'b0;
    checks++; if (pc !== 32'h40 || epc !== 32'h0 || cause !== 2'b01) begin errors++; $display("FAIL same_exc got=%h/%h/%b exp=40/0/01", pc, epc, cause); end
    tick();
    checks++; if (irq_ack !== 1'b0) begin errors++; $display("FAIL same_masked got=%b exp=0", irq_ack); end
    eret = 1'b1;
    tick();
    eret = 1'b0;
    checks++; if (pc !== 32'h0 || irq_ack !== 1'b1 || go !== 1'b1) begin errors++; $display("FAIL same_irq_after got=%h/%b/%b exp=0/1/1", pc, irq_ack, go); end
    tick();
    checks++; if (pc !== 32'h40 || epc !== 32'h1 || cause !== 2'b10) begin errors++; $display("FAIL same_irq_enter got=%h/%h/%b exp=40/1/10", pc, epc, cause); end
    irq = 1'b0;
    tick();
    tick();
    tick();
    eret = 1'b1;
    tick();
    eret = 1'b0;
    checks++; if (pc !== 32'h1 || in_handler !== 1'b0) begin errors++; $display("FAIL same_ret got=%h/%b exp=1/0", pc, in_handler); end
  endtask
`else
  task automatic test_irq_disabled();
    irq = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (irq_ack !== 1'b0 || in_handler !== 1'b0 || pc !== 32'h34 + 32'(i)) begin errors++; $display("FAIL irq_off got=%b/%b/%h exp=0/0/%h", irq_ack, in_handler, pc, 32'h34 + 32'(i)); end
    end
    exc_req = 1'b1; exc_pc = 32'hFFFF_FFFF;
    #1;
    checks++; if (go !== 1'b1) begin errors++; $display("FAIL wrap_go got=%b exp=1", go); end
    tick();
    exc_req = 1'b0;
    checks++; if (pc !== 32'h40 || epc !== 32'h0 || cause !== 2'b01) begin errors++; $display("FAIL wrap_exc got=%h/%h/%b exp=40/0/01", pc, epc, cause); end
    eret = 1'b1;
    tick();
    eret = 1'b0;
    checks++; if (pc !== 32'h0 || irq_ack !== 1'b0 || go !== 1'b0) begin errors++; $display("FAIL wrap_ret got=%h/%b/%b exp=0/0/0", pc, irq_ack, go); end
    tick();
    checks++; if (pc !== 32'h1 || in_handler !== 1'b0) begin errors++; $display("FAIL wrap_run got=%h/%b exp=1/0", pc, in_handler); end
    irq = 1'b0;
  endtask
`endif

  task automatic test_reset_mid_handler();
    exc_req = 1'b1; exc_pc = 32'h5;
    tick();
    exc_req = 1'b0;
    checks++; if (in_handler !== 1'b1 || pc !== 32'h40) begin errors++; $display("FAIL mid_enter got=%b/%h exp=1/40", in_handler, pc); end
    #2;
    rst = 1'b0;
    #1;
    checks++; if (in_handler !== 1'b0 || pc !== 32'h0) begin errors++; $display("FAIL mid_rst got=%b/%h exp=0/0", in_handler, pc); end
    checks++; if (double_fault !== 1'b0 || epc !== 32'h0 || cause !== 2'b00) begin errors++; $display("FAIL mid_rst_regs got=%b/%h/%b exp=0/0/00", double_fault, epc, cause); end
    tick();
    rst = 1'b1;
    tick();
    checks++; if (pc !== 32'h1 || in_handler !== 1'b0) begin errors++; $display("FAIL mid_resume got=%h/%b exp=1/0", pc, in_handler); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_sequential();
    test_branch();
    test_exception();
    test_eret();
    test_double_fault();
`ifdef IF_PC_IRQ_EN
    test_irq();
    test_exc_irq_same();
`else
    test_irq_disabled();
`endif
    test_reset_mid_handler();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/if_pc_gen.md
# if_pc_gen

Fetch-stage program-counter generator that drives the instruction ROM address and its flush input. It selects the next word-address PC (sequential, branch, exception or interrupt vector, or return-from-handler), tracks whether the core is inside the handler, and holds EPC and cause. It sits directly upstream of the instruction ROM: `pc` feeds the ROM address, and `gohandle_or_not` feeds the ROM flush.

## Interface
- `RESET_PC`, 32'h0000_0000, PC loaded by reset (word address)
- `HANDLER_PC`, 32'h0000_0040, single handler entry (word address, inside the 7-bit ROM space)
- `clk` in 1, the single clock
- `rst` in 1, asynchronous, active-low (0 = reset)
- `stall` in 1, hazard hold; blocks branch and increment
- `br_taken` in 1, branch redirect from ID
- `br_target` in 32, branch target (word address)
- `exc_req` in 1, synchronous exception from a later stage
- `exc_pc` in 32, PC of the faulting instruction
- `irq` in 1, asynchronous external interrupt, level
- `eret` in 1, return-from-handler decoded
- `pc` out 32, current fetch address to the ROM
- `gohandle_or_not` out 1, ROM flush for the current cycle
- `epc` out 32, saved return PC
- `cause` out 2, 2'b01 = exception, 2'b10 = interrupt
- `in_handler` out 1, high while in the HANDLE state
- `irq_ack` out 1, interrupt taken this cycle
- `double_fault` out 1, sticky: an exception arrived while in HANDLE

## Operation
- State machine with two states, RUN and HANDLE.
- `irq_s` is `irq` after the two-flop synchroniser.
- Redirect priority, highest first:
  1. RUN and `exc_req`: take the exception. `epc` ← `exc_pc`+1, `cause` ← 01, `pc` ← HANDLER_PC, go to HANDLE.
  2. RUN and `irq_s`: take the interrupt. `epc` ← the sequential next PC (`br_target` if `br_taken`, else `pc`+1; `pc` if `stall` and no branch). `cause` ← 10, `pc` ← HANDLER_PC, `irq_ack`=1, go to HANDLE.
  3. HANDLE and `eret`: `pc` ← `epc`, go to RUN; `cause` is held.
  4. `br_taken` and not `stall`: `pc` ← `br_target`.
  5. not `stall`: `pc` ← `pc`+1.
  6. Otherwise `pc` holds.
- Exception, interrupt and eret redirects all override `stall`.
- `gohandle_or_not` = take-exception | take-interrupt | take-eret. It is combinational and only registered inputs feed it, so it is stable before the falling edge.
- In HANDLE:
  - `irq_s` is ignored (masked).
  - `exc_req` sets `double_fault` and causes no redirect.
  - The handler continues with rules 4–6.
- `eret` in RUN is ignored.
- Arithmetic is 32-bit modulo; `pc`+1 and `exc_pc`+1 wrap from 32'hFFFF_FFFF to 0.
- `double_fault` clears only on reset.

## Timing
- Reset values:
  - `pc`=RESET_PC, state RUN, `epc`=0, `cause`=0, `double_fault`=0.
  - `in_handler`=0, `gohandle_or_not`=0, `irq_ack`=0; the combinational outputs are forced to 0 while `rst`=0.
- Reset applied mid-handler returns to RUN immediately.
- Register updates occur on the rising edge of `clk`; the ROM samples `pc` on the following falling edge.
- Redirect latency:
  - The decision is made in cycle k, and `gohandle_or_not`=1 in cycle k zeroes that cycle's wrong-path fetch.
  - `pc`=target from cycle k+1.
- Interrupt latency: 2 cycles of synchronisation plus the redirect cycle.
- `irq_ack` and `gohandle_or_not` are single-cycle per take.
- A level `irq` that is still high after `eret` is taken again: the earliest re-entry is the cycle after return to RUN.
- `exc_req` and `irq_s` in the same cycle: the exception wins, and the interrupt is taken after `eret`.
- `eret` and `exc_req` in the same HANDLE cycle: `eret` wins and `double_fault` is set.

## Configuration
- `IF_PC_IRQ_EN`
  - Defined: interrupt path, synchroniser and `irq_ack` are present.
  - Undefined: `irq` is ignored, `irq_ack` is tied 0, the synchroniser is not instantiated, and exception and eret behaviour is unchanged.

## Structure
- Shared package `if_pc_pkg`:
  - State enum (RUN, HANDLE).
  - Cause codes CAUSE_EXC=2'b01 and CAUSE_IRQ=2'b10.
  - Default RESET_PC and HANDLER_PC constants.
- One sub-module, `irq_sync2`: a two-flop synchroniser with active-low asynchronous reset to 0.
- Everything else is flat: next-PC mux, state register, EPC/cause registers.

## Test plan
- Reset then 4 free cycles → `pc` goes 0,1,2,3,4; `gohandle_or_not`=0.
- At `pc`=5, `br_taken`=1 with `br_target`=0x20 → `pc`=0x20 next cycle. Repeat with `stall`=1 → `pc` holds 5.
- At `pc`=9, `exc_req`=1 with `exc_pc`=7, `stall`=1 → same cycle `gohandle_or_not`=1. Next cycle `pc`=0x40, `epc`=8, `cause`=01, `in_handler`=1.
- In HANDLE, `eret` → `pc`=`epc` next cycle, `in_handler`=0. Also `exc_req` plus `eret` together → return taken, `double_fault`=1 and held.
- With `IF_PC_IRQ_EN`: at `pc`=0x10, raise `irq` → two cycles later `irq_ack`=1, `epc`=the next sequential PC, `cause`=10. `irq` held in HANDLE → no second entry.
- `exc_req` and `irq` both high in RUN with `exc_pc`=0xFFFF_FFFF → exception taken, `epc`=0. After `eret`, the interrupt is taken.
